// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch sequencer:
//   - state_e       : IDLE / RUN / DONE sequencer states
//   - OPC_HALT/NOP  : opcode values the fetch unit recognises or emits
//   - OPC_* / OPR_* : bit positions of the opcode and operand fields
//   - JUMP_LUT      : absolute jump-target table, only consulted when the
//                     design is built with FETCH_JUMP_LUT_EN defined
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] OPC_HALT = 4'b1111;
    localparam logic [3:0] OPC_NOP  = 4'b0101;  // add, never a jump or store

    // Instruction field layout: opcode = instr[8:5], operand = instr[4:0].
    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 5;
    localparam int OPR_MSB = 4;
    localparam int OPR_LSB = 0;
    localparam int OPR_W   = OPR_MSB - OPR_LSB + 1;

    localparam int LUT_DEPTH = 32;
    localparam int LUT_W     = 16;  // wide enough for any sensible PC_W

    // Absolute jump targets indexed by the 5-bit operand.
    localparam logic [LUT_W-1:0] JUMP_LUT [LUT_DEPTH] = '{
        16'd0,    16'd100,  16'd200,  16'd300,
        16'd400,  16'd500,  16'd600,  16'd700,
        16'd800,  16'd900,  16'd1000, 16'd16,
        16'd32,   16'd48,   16'd64,   16'd80,
        16'd96,   16'd112,  16'd128,  16'd144,
        16'd160,  16'd176,  16'd192,  16'd208,
        16'd224,  16'd240,  16'd256,  16'd272,
        16'd288,  16'd512,  16'd768,  16'd1023
    };

endpackage : fetch_pkg

// File: rtl/fetch_unit_jump_target.sv
// ---------------------------------------------------------------------------
// fetch_unit_jump_target (module jump_target)
// Combinational jump-target generator.
//   pc_i      : current program counter
//   operand_i : 5-bit operand field of the current instruction
//   target_o  : address loaded into the PC when a jump is taken
// Build option FETCH_JUMP_LUT_EN: when defined the target is the absolute
// address JUMP_LUT[operand]; otherwise it is pc + sign_extend(operand),
// wrapping modulo 2^PC_W.
// ---------------------------------------------------------------------------
module jump_target
    import fetch_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0]  pc_i,
    input  logic [OPR_W-1:0] operand_i,
    output logic [PC_W-1:0]  target_o
);

`ifdef FETCH_JUMP_LUT_EN
    // The PC is not needed for absolute targets; fold it away explicitly.
    logic unused_pc;
    assign unused_pc = ^pc_i;

    logic [LUT_W-1:0] lut_entry;
    assign lut_entry = JUMP_LUT[operand_i];
    assign target_o  = lut_entry[PC_W-1:0];
`else
    // Two's-complement offset -16..+15; the sum naturally wraps at 2^PC_W.
    logic [PC_W-1:0] offset;
    assign offset   = {{(PC_W-OPR_W){operand_i[OPR_W-1]}}, operand_i};
    assign target_o = pc_i + offset;
`endif

endmodule : jump_target

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Program counter and start/run/done fetch sequencer feeding the control
// decoder. Addresses the combinational instruction ROM, splits the fetched
// word into opcode/operand, chooses the next PC from the decoder jump
// outputs and the ALU flag, and counts RUN cycles for benchmarking.
//
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   start          : level-sampled request to begin at start_addr
//   start_addr     : PC loaded when a start is accepted (IDLE or DONE)
//   instr_in       : ROM data for address pc, same cycle
//   uncd_jmp       : decoder unconditional-jump
//   jtype          : decoder conditional-jump
//   flag           : ALU compare flag
//   pc             : ROM address
//   opcode         : instr_in[8:5] in RUN, OPC_NOP otherwise
//   operand        : instr_in[4:0]
//   running, done  : registered state decodes
//   cycle_cnt      : saturating count of RUN cycles since last start
//
// Build option FETCH_JUMP_LUT_EN selects absolute LUT jump targets (handled
// entirely inside jump_target).
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    start_addr,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               uncd_jmp,
    input  logic               jtype,
    input  logic               flag,
    output logic [PC_W-1:0]    pc,
    output logic [3:0]         opcode,
    output logic [OPR_W-1:0]   operand,
    output logic               running,
    output logic               done,
    output logic [CNT_W-1:0]   cycle_cnt
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0]        instr_opc;
    logic [PC_W-1:0]   target;
    logic              take;
    logic              is_halt;

    assign instr_opc = instr_in[OPC_MSB:OPC_LSB];
    assign operand   = instr_in[OPR_MSB:OPR_LSB];
    assign is_halt   = (instr_opc == OPC_HALT);
    assign take      = uncd_jmp | (jtype & flag);

    jump_target #(
        .PC_W(PC_W)
    ) u_jump_target (
        .pc_i      (pc_q),
        .operand_i (operand),
        .target_o  (target)
    );

    // NOTE: every signal gets a hold default before the case so no path
    // leaves one unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = start_addr;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                // Every RUN cycle counts, including the HALT cycle.
                cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                // HALT wins over a jump decoded in the same cycle.
                if (is_halt) begin
                    state_d = ST_DONE;
                end else if (take) begin
                    pc_d = target;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc        = pc_q;
    assign cycle_cnt = cnt_q;
    assign running   = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);

    // Outside RUN the decoder must see a harmless opcode.
    assign opcode    = running ? instr_opc : OPC_NOP;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A 1024-entry instruction ROM model drives
// instr_in from pc. Single-step jump/increment vectors come from a table;
// sequential fetch, restart, saturation and asynchronous reset are
// hand-written sequences. The DUT uses CNT_W=4 to reach saturation quickly.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int CNT_W   = 4;

    localparam logic [3:0] HALT = 4'b1111;
    localparam logic [3:0] NOP  = 4'b0101;
    localparam logic [3:0] OTHER = 4'b0011;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [PC_W-1:0]    start_addr;
    logic [INSTR_W-1:0] instr_in;
    logic               uncd_jmp;
    logic               jtype;
    logic               flag;
    logic [PC_W-1:0]    pc;
    logic [3:0]         opcode;
    logic [4:0]         operand;
    logic               running;
    logic               done;
    logic [CNT_W-1:0]   cycle_cnt;

    logic [INSTR_W-1:0] rom [1024];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign instr_in = rom[pc];

    fetch_unit #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .instr_in   (instr_in),
        .uncd_jmp   (uncd_jmp),
        .jtype      (jtype),
        .flag       (flag),
        .pc         (pc),
        .opcode     (opcode),
        .operand    (operand),
        .running    (running),
        .done       (done),
        .cycle_cnt  (cycle_cnt)
    );

    typedef struct {
        string              name;
        logic [PC_W-1:0]    sa;
        logic [INSTR_W-1:0] instr;
        logic               uj;
        logic               jt;
        logic               fl;
        logic [PC_W-1:0]    exp_pc;
        logic               exp_run;
        logic               exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    function automatic vec_t mk(input string name, input int sa, input logic [3:0] opc,
                                input logic [4:0] opr, input logic uj, input logic jt,
                                input logic fl, input int exp_pc, input logic er,
                                input logic ed);
        vec_t v;
        v.name = name; v.sa = PC_W'(sa); v.instr = {opc, opr};
        v.uj = uj; v.jt = jt; v.fl = fl; v.exp_pc = PC_W'(exp_pc);
        v.exp_run = er; v.exp_done = ed;
        return v;
    endfunction

    // Leaves the bench at a falling edge with the DUT idle and the ROM cleared.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0; start_addr = '0;
        uncd_jmp = 1'b0; jtype = 1'b0; flag = 1'b0;
        for (int i = 0; i < 1024; i++) rom[i] = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_at(input logic [PC_W-1:0] addr);
        start_addr = addr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; start_addr = '0;
        uncd_jmp = 1'b0; jtype = 1'b0; flag = 1'b0;
        for (int i = 0; i < 1024; i++) rom[i] = '0;

        // ---- reset values ----
        #1;
        check("rst_pc",      pc, 0);
        check("rst_running", running, 0);
        check("rst_done",    done, 0);
        check("rst_cnt",     cycle_cnt, 0);
        check("rst_opcode",  opcode, NOP);

        // ---- single-step vector table ----
`ifdef FETCH_JUMP_LUT_EN
        vecs.push_back(mk("lut_jump3",     10,   OTHER, 5'd3,     1, 0, 0, 300,  1, 0));
        vecs.push_back(mk("lut_cond_flag", 20,   OTHER, 5'd10,    0, 1, 1, 1000, 1, 0));
        vecs.push_back(mk("lut_cond_nof",  20,   OTHER, 5'd10,    0, 1, 0, 21,   1, 0));
`else
        vecs.push_back(mk("cond_flag1",    20,   OTHER, 5'b11100, 0, 1, 1, 16,   1, 0));
        vecs.push_back(mk("cond_flag0",    20,   OTHER, 5'b11100, 0, 1, 0, 21,   1, 0));
        vecs.push_back(mk("uncd_wrap",     0,    OTHER, 5'b10000, 1, 0, 0, 1008, 1, 0));
        vecs.push_back(mk("uncd_fwd15",    100,  OTHER, 5'b01111, 1, 0, 0, 115,  1, 0));
        vecs.push_back(mk("self_loop",     50,   OTHER, 5'b00000, 1, 0, 0, 50,   1, 0));
        vecs.push_back(mk("rel_jump3",     10,   OTHER, 5'd3,     1, 0, 0, 13,   1, 0));
        vecs.push_back(mk("fwd_wrap",      1020, OTHER, 5'b00101, 1, 0, 0, 1,    1, 0));
`endif
        vecs.push_back(mk("flag_no_jtype", 200,  OTHER, 5'b00100, 0, 0, 1, 201,  1, 0));
        vecs.push_back(mk("pc_wrap",       1023, OTHER, 5'b00001, 0, 0, 0, 0,    1, 0));
        vecs.push_back(mk("halt_vs_jump",  300,  HALT,  5'b00101, 1, 1, 1, 300,  0, 1));

        foreach (vecs[k]) begin
            do_reset();
            rom[vecs[k].sa] = vecs[k].instr;
            start_at(vecs[k].sa);
            check({vecs[k].name, "_pc0"},     pc, vecs[k].sa);
            check({vecs[k].name, "_opcode"},  opcode, vecs[k].instr[8:5]);
            check({vecs[k].name, "_operand"}, operand, vecs[k].instr[4:0]);
            uncd_jmp = vecs[k].uj; jtype = vecs[k].jt; flag = vecs[k].fl;
            @(negedge clk);
            uncd_jmp = 1'b0; jtype = 1'b0; flag = 1'b0;
            check({vecs[k].name, "_pc1"},     pc, vecs[k].exp_pc);
            check({vecs[k].name, "_running"}, running, vecs[k].exp_run);
            check({vecs[k].name, "_done"},    done, vecs[k].exp_done);
        end

        // ---- sequential fetch 5..9, HALT at 9 ----
        do_reset();
        rom[9] = {HALT, 5'd0};
        check("idle_opcode_gated", opcode, NOP);
        start_at(10'd5);
        check("seq_running", running, 1);
        for (int a = 5; a <= 9; a++) begin
            check($sformatf("seq_pc%0d", a), pc, a);
            @(negedge clk);
        end
        check("seq_done",     done, 1);
        check("seq_run_low",  running, 0);
        check("seq_cnt",      cycle_cnt, 5);
        check("seq_pc_hold",  pc, 9);
        check("done_opcode",  opcode, NOP);
        check("done_operand", operand, 0);
        @(negedge clk);
        @(negedge clk);
        check("done_pc_frozen",  pc, 9);
        check("done_cnt_frozen", cycle_cnt, 5);
        check("done_stays",      done, 1);

        // ---- restart from DONE ----
        start_at(10'd5);
        check("restart_running", running, 1);
        check("restart_done",    done, 0);
        check("restart_pc",      pc, 5);
        check("restart_cnt",     cycle_cnt, 0);

        // ---- start ignored while running ----
        start_addr = 10'd600; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored_pc",  pc, 6);
        check("start_ignored_cnt", cycle_cnt, 1);

        // ---- saturation with CNT_W=4 ----
        do_reset();
        start_at(10'd0);
        repeat (20) @(negedge clk);
        check("sat_cnt",     cycle_cnt, 15);
        check("sat_running", running, 1);
        check("sat_pc",      pc, 20);

        // ---- asynchronous reset mid-RUN at pc=37 ----
        do_reset();
        start_at(10'd30);
        repeat (7) @(negedge clk);
        check("pre_rst_pc", pc, 37);
        #2 reset = 1'b1;
        #1;
        check("async_rst_pc",      pc, 0);
        check("async_rst_running", running, 0);
        check("async_rst_done",    done, 0);
        check("async_rst_cnt",     cycle_cnt, 0);
        check("async_rst_opcode",  opcode, NOP);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle_pc", pc, 0);
        check("post_rst_idle",    running, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch sequencer directly upstream of the control decoder. Holds the PC and addresses the combinational instruction ROM. Splits the fetched 9-bit instruction into the 4-bit opcode for the decoder plus a 5-bit operand. Consumes the decoder's jump outputs and the ALU compare flag to choose the next PC. Runs a start/run/done sequence and counts executed cycles for benchmarking.

## Interface

Parameters:
- PC_W, 10, PC / instruction-ROM address width
- INSTR_W, 9, instruction width; opcode = instr[8:5], operand = instr[4:0]
- CNT_W, 16, cycle-counter width

Ports:
- clk  in  1  system clock; the block's only clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request to begin execution at start_addr
- start_addr  in  PC_W  PC loaded on accepted start
- instr_in  in  INSTR_W  ROM data for address pc, valid in the same cycle
- uncd_jmp  in  1  decoder UncdJmp
- jtype  in  1  decoder JType
- flag  in  1  condition flag from the ALU compare register
- pc  out  PC_W  ROM address
- opcode  out  4  instr_in[8:5]; forced to 4'b0101 (add, no jump) when not RUN
- operand  out  5  instr_in[4:0]
- running  out  1  high in RUN
- done  out  1  high in DONE
- cycle_cnt  out  CNT_W  cycles spent in RUN since last accepted start

## Operation

- States: IDLE, RUN, DONE (2-bit enum).
- IDLE:
  - start=1 → RUN, pc ← start_addr, cycle_cnt ← 0.
  - Otherwise hold.
- RUN:
  - If instr_in[8:5]==4'b1111 (HALT) → DONE; pc holds; the HALT cycle is counted.
  - Else if take = uncd_jmp | (jtype & flag) → pc ← target.
  - Else pc ← pc + 1, modulo 2^PC_W (address 2^PC_W−1 wraps to 0).
  - start is ignored in RUN.
- DONE:
  - start=1 → RUN with the same actions as from IDLE (restart).
  - Otherwise hold; pc and cycle_cnt frozen.
- HALT takes priority over a jump in the same cycle.
- Default target: pc + sign_extend(operand), a 5-bit two's-complement offset of −16..+15 with modulo-2^PC_W wrap. Offset 0 is a legal self-loop.
- cycle_cnt increments once per RUN cycle and saturates at all-ones; no wrap.
- opcode is gated outside RUN so the decoder never asserts a jump or store while idle.

## Timing

- Reset values: state=IDLE, pc=0, cycle_cnt=0, running=0, done=0. opcode=4'b0101; operand follows instr_in.
- running and done are registered state decodes.
- opcode and operand are combinational from instr_in; the decoder sees an instruction in the same cycle pc addresses it.
- Single-cycle PC update:
  - The decision in cycle N uses that cycle's uncd_jmp, jtype and flag.
  - The new pc is visible in cycle N+1.
  - There are no delay slots and no bubbles.
- start is level-sampled on the clock edge. Start accepted in cycle N → running=1 and pc=start_addr in N+1.
- HALT fetched in cycle N → done=1 and running=0 in N+1.
- Reset asserted at any time, including mid-RUN, returns all state to reset values immediately; no partial PC update survives.

## Configuration

- FETCH_JUMP_LUT_EN defined: the jump target is absolute, target = lut[operand].
  - lut is a 32-entry constant table of PC_W-bit addresses.
  - The relative adder path is not compiled.
- Not defined: relative target only, as described in Operation.
- All other behaviour is identical in both builds.

## Structure

- Shared package fetch_pkg:
  - state enum (IDLE/RUN/DONE)
  - OPC_HALT=4'b1111 and OPC_NOP=4'b0101
  - the operand-field bit positions
  - the 32-entry JUMP_LUT constant array, used only under FETCH_JUMP_LUT_EN
- Sub-module jump_target:
  - combinational
  - inputs pc and operand; output target
  - contains the ifdef'd LUT/relative selection, so fetch_unit stays build-agnostic.

## Test plan

- Reset check: assert reset mid-RUN at pc=37 → pc=0, IDLE, done=0 and cycle_cnt=0 immediately, without waiting for a clock edge.
- Sequential fetch: start with start_addr=5, no jumps; opcode 1111 placed at address 9 → pc steps 5,6,7,8,9. done rises the next cycle; cycle_cnt=5.
- Conditional jump, relative build:
  - At pc=20, jtype=1, operand=5'b11100 (−4).
  - flag=1 → next pc=16.
  - flag=0 → next pc=21.
- Unconditional jump at pc=0 with operand=5'b10000 (−16) → pc=1008 (wrap); uncd_jmp=1 with flag=0 still taken.
- LUT build (FETCH_JUMP_LUT_EN): lut[3]=300; jump at pc=10 with operand=3 → next pc=300. Relative offset ignored.
- Boundaries:
  - pc=1023 with no jump → pc=0.
  - HALT with uncd_jmp=1 → DONE and pc holds.
  - cycle_cnt with CNT_W=4 stays at 15 after 20 RUN cycles.
  - start during DONE restarts and clears cycle_cnt.
